// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-master round-robin sequencer for the shared register-file port
//
// Purpose: accepts word requests from master 0 (CPU core) and master 1 (debug/DMA),
// runs one register-file access at a time and returns data plus a one-cycle ack_.
// A timeout on rf_rdy_ keeps a dead slave from hanging either master.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   m0_req_/m1_req_             request, active low, held with fields until ack_
//   m0_addr/m1_addr             register address
//   m0_wdata/m1_wdata           write data
//   m0_we_/m1_we_               write enable, active low (1 = read)
//   m0_ack_/m1_ack_             completion strobe, active low, one cycle
//   m0_rdata/m1_rdata           read data, valid with ack_, held afterwards
//   m0_err/m1_err               set with ack_ when the access timed out
//   rf_addr, rf_d_in            register-file address and write data
//   rf_bus                      register-file read data
//   rf_we_, rf_as_, rf_cs_      register-file strobes, active low
//   rf_rdy_                     register-file ready, active low
//   gnt                         index of the granted master
//   busy                        high whenever the sequencer is not idle

module regfile_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we_,
    output logic              m0_ack_,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req_,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we_,
    output logic              m1_ack_,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_d_in,
    input  logic [DATA_W-1:0] rf_bus,
    output logic              rf_we_,
    output logic              rf_as_,
    output logic              rf_cs_,
    input  logic              rf_rdy_,

    output logic              gnt,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic              gnt_q;
    logic              busy_q;

    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_d_in_q;
    logic              rf_we_q;
    logic              rf_as_q;
    logic              rf_cs_q;

    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              m0_err_q;
    logic              m1_err_q;

    // Arbitration: a lone requester wins; on a tie the master not served last wins.
    logic              any_req;
    logic              pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    always_comb begin
        any_req   = 1'b0;
        pick      = 1'b0;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_we    = m0_we_;
        any_req   = !m0_req_ || !m1_req_;
        if (!m0_req_ && !m1_req_) begin
            pick = !last_q;
        end else begin
            pick = !m1_req_;
        end
        if (pick) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_we    = m1_we_;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            rf_addr_q  <= '0;
            rf_d_in_q  <= '0;
            rf_we_q    <= 1'b1;
            rf_as_q    <= 1'b1;
            rf_cs_q    <= 1'b1;
            m0_ack_q   <= 1'b1;
            m1_ack_q   <= 1'b1;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            // ack_ is a single-cycle pulse; it is pulled low only on completion.
            m0_ack_q <= 1'b1;
            m1_ack_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q     <= pick;
                        rf_addr_q <= sel_addr;
                        rf_d_in_q <= sel_wdata;
                        rf_we_q   <= sel_we;
                        rf_cs_q   <= 1'b0;
                        rf_as_q   <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (!rf_rdy_) begin
                        // rf_we_q still holds the granted direction here, so a
                        // high value marks a read whose data must be returned.
                        if (gnt_q) begin
                            m1_ack_q <= 1'b0;
                            m1_err_q <= 1'b0;
                            if (rf_we_q) begin
                                m1_rdata_q <= rf_bus;
                            end
                        end else begin
                            m0_ack_q <= 1'b0;
                            m0_err_q <= 1'b0;
                            if (rf_we_q) begin
                                m0_rdata_q <= rf_bus;
                            end
                        end
                        last_q  <= gnt_q;
                        rf_cs_q <= 1'b1;
                        rf_as_q <= 1'b1;
                        rf_we_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Dead slave: complete with error, read data untouched.
                        if (gnt_q) begin
                            m1_ack_q <= 1'b0;
                            m1_err_q <= 1'b1;
                        end else begin
                            m0_ack_q <= 1'b0;
                            m0_err_q <= 1'b1;
                        end
                        last_q  <= gnt_q;
                        rf_cs_q <= 1'b1;
                        rf_as_q <= 1'b1;
                        rf_we_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_RELEASE: begin
                    // Wait for the slave to drop rdy_ so a stale ready cannot
                    // complete the next access; give up after TIMEOUT cycles.
                    if (rf_rdy_ || (cnt_q == CNT_LAST)) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    rf_cs_q <= 1'b1;
                    rf_as_q <= 1'b1;
                    rf_we_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack_  = m0_ack_q;
    assign m1_ack_  = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign rf_addr  = rf_addr_q;
    assign rf_d_in  = rf_d_in_q;
    assign rf_we_   = rf_we_q;
    assign rf_as_   = rf_as_q;
    assign rf_cs_   = rf_cs_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter

module tb_regfile_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;

    logic              m0_req_ = 1'b1;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m0_we_ = 1'b1;
    logic              m0_ack_;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req_ = 1'b1;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m1_we_ = 1'b1;
    logic              m1_ack_;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_d_in;
    logic [DATA_W-1:0] rf_bus = '0;
    logic              rf_we_;
    logic              rf_as_;
    logic              rf_cs_;
    logic              rf_rdy_ = 1'b1;
    logic              gnt;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Slave controls, written only by the stimulus process.
    logic              dead = 1'b0;
    int                stretch_n = 0;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    int                hold_q = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .m0_req_(m0_req_), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we_(m0_we_),
        .m0_ack_(m0_ack_), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req_(m1_req_), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_(m1_we_),
        .m1_ack_(m1_ack_), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rf_addr(rf_addr), .rf_d_in(rf_d_in), .rf_bus(rf_bus), .rf_we_(rf_we_),
        .rf_as_(rf_as_), .rf_cs_(rf_cs_), .rf_rdy_(rf_rdy_),
        .gnt(gnt), .busy(busy)
    );

    // Register-file model: rdy_ one cycle after strobes, drops one cycle after
    // they rise, optionally stretched by stretch_n cycles; dead keeps rdy_ high.
    always @(posedge clk) begin
        if (dead) begin
            rf_rdy_ <= 1'b1;
            hold_q  <= 0;
        end else if (!rf_cs_ && !rf_as_) begin
            rf_rdy_ <= 1'b0;
            hold_q  <= stretch_n;
            if (!rf_we_) mem[rf_addr] <= rf_d_in;
            rf_bus  <= mem[rf_addr];
        end else if (hold_q != 0) begin
            rf_rdy_ <= 1'b0;
            hold_q  <= hold_q - 1;
        end else begin
            rf_rdy_ <= 1'b1;
        end
    end

    task automatic wait_ack(input int m, input int max_cycles, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if ((m == 0 && m0_ack_ === 1'b0) || (m == 1 && m1_ack_ === 1'b0)) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        ok = (busy === 1'b0);
        while (!ok && n < 40) begin
            @(negedge clk);
            n++;
            ok = (busy === 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rf_cs_, rf_as_, rf_we_} !== 3'b111) begin
            errors++; $display("FAIL reset_strobes: got %b want 111", {rf_cs_, rf_as_, rf_we_});
        end
        checks++;
        if ({m0_ack_, m1_ack_, m0_err, m1_err, gnt, busy} !== 6'b110000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 110000", {m0_ack_, m1_ack_, m0_err, m1_err, gnt, busy});
        end
        checks++;
        if (rf_addr !== '0 || rf_d_in !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++; $display("FAIL reset_data: addr=%h d_in=%h r0=%h r1=%h want 0", rf_addr, rf_d_in, m0_rdata, m1_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        m0_addr = 5'd0; m0_we_ = 1'b1; m0_req_ = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_cs_ !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_access_started: cs_=%b busy=%b want 0 1", rf_cs_, busy);
        end
        reset = 1'b1; m0_req_ = 1'b1;
        @(negedge clk);
        checks++;
        if ({rf_cs_, rf_as_, m0_ack_, busy} !== 4'b1110) begin
            errors++; $display("FAIL mid_access_reset: cs_,as_,ack_,busy=%b want 1110", {rf_cs_, rf_as_, m0_ack_, busy});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m0_ack_ !== 1'b1) begin
                errors++; $display("FAIL aborted_no_ack: m0_ack_=%b want 1 (cycle %0d)", m0_ack_, i);
            end
        end
    endtask

    task automatic test_write_read;
        int cyc; bit ok;
        m0_addr = 5'd3; m0_wdata = 32'hDEADBEEF; m0_we_ = 1'b0; m0_req_ = 1'b0;
        wait_ack(0, 40, cyc, ok);
        m0_req_ = 1'b1; m0_we_ = 1'b1;
        checks++;
        if (!ok || cyc != 3) begin
            errors++; $display("FAIL write_latency: ack seen=%0d after %0d cycles want 3", ok, cyc);
        end
        checks++;
        if (m0_err !== 1'b0) begin
            errors++; $display("FAIL write_err: m0_err=%b want 0", m0_err);
        end
        @(negedge clk);
        checks++;
        if (m0_ack_ !== 1'b1) begin
            errors++; $display("FAIL write_ack_width: m0_ack_=%b want 1", m0_ack_);
        end
        wait_idle(ok);
        m0_req_ = 1'b0;
        wait_ack(0, 40, cyc, ok);
        m0_req_ = 1'b1;
        checks++;
        if (!ok || cyc != 3) begin
            errors++; $display("FAIL read_latency: ack seen=%0d after %0d cycles want 3", ok, cyc);
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF || m0_err !== 1'b0) begin
            errors++; $display("FAIL read_data: rdata=%h err=%b want deadbeef 0", m0_rdata, m0_err);
        end
        @(negedge clk);
        checks++;
        if (m0_ack_ !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_hold: ack_=%b rdata=%h want 1 deadbeef", m0_ack_, m0_rdata);
        end
        wait_idle(ok);
    endtask

    task automatic test_round_robin;
        bit ok;
        int n;
        int winner;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m0_addr = 5'd3; m0_we_ = 1'b1;
        m1_addr = 5'd3; m1_we_ = 1'b1;
        m0_req_ = 1'b0; m1_req_ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0; n = 0; winner = -1;
            while (!ok && n < 40) begin
                @(negedge clk);
                n++;
                if (m0_ack_ === 1'b0 || m1_ack_ === 1'b0) ok = 1'b1;
            end
            if (m0_ack_ === 1'b0 && m1_ack_ === 1'b1) winner = 0;
            else if (m1_ack_ === 1'b0 && m0_ack_ === 1'b1) winner = 1;
            checks++;
            if (!ok || winner != (k % 2) || gnt !== 1'((k % 2))) begin
                errors++; $display("FAIL rr_order: access %0d winner=%0d gnt=%b want %0d", k, winner, gnt, k % 2);
            end
        end
        m0_req_ = 1'b1; m1_req_ = 1'b1;
        checks++;
        if (m1_rdata !== 32'hDEADBEEF || m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rr_data: r0=%h r1=%h want deadbeef", m0_rdata, m1_rdata);
        end
        wait_idle(ok);
    endtask

    task automatic test_timeout;
        int cyc; bit ok;
        dead = 1'b1;
        m1_addr = 5'd5; m1_we_ = 1'b1; m1_req_ = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 1'b1 || rf_cs_ !== 1'b0) begin
            errors++; $display("FAIL timeout_grant: gnt=%b cs_=%b want 1 0", gnt, rf_cs_);
        end
        m0_addr = 5'd3; m0_we_ = 1'b1; m0_req_ = 1'b0;
        wait_ack(1, 40, cyc, ok);
        m1_req_ = 1'b1; dead = 1'b0;
        checks++;
        if (!ok || cyc != 15) begin
            errors++; $display("FAIL timeout_latency: ack seen=%0d after %0d+1 cycles want 15+1", ok, cyc);
        end
        checks++;
        if (m1_err !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m0_ack_ !== 1'b1) begin
            errors++; $display("FAIL timeout_err: err=%b rdata=%h m0_ack_=%b want 1 deadbeef 1", m1_err, m1_rdata, m0_ack_);
        end
        wait_ack(0, 40, cyc, ok);
        m0_req_ = 1'b1;
        checks++;
        if (!ok || gnt !== 1'b0 || m0_err !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL timeout_next_m0: ok=%0d gnt=%b err=%b rdata=%h want 1 0 0 deadbeef", ok, gnt, m0_err, m0_rdata);
        end
        wait_idle(ok);
    endtask

    task automatic test_release_hold;
        int cyc; bit ok;
        stretch_n = 3;
        m0_addr = 5'd3; m0_we_ = 1'b1; m0_req_ = 1'b0;
        @(negedge clk);
        m1_addr = 5'd3; m1_we_ = 1'b1; m1_req_ = 1'b0;
        wait_ack(0, 40, cyc, ok);
        m0_req_ = 1'b1;
        checks++;
        if (!ok || cyc != 2) begin
            errors++; $display("FAIL hold_m0_ack: ack seen=%0d after %0d+1 cycles want 2+1", ok, cyc);
        end
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (rf_cs_ !== 1'b1 || rf_as_ !== 1'b1) begin
                errors++; $display("FAIL hold_no_strobe: cycle %0d cs_=%b as_=%b want 1 1", i, rf_cs_, rf_as_);
            end
        end
        while (rf_cs_ !== 1'b0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 6 || gnt !== 1'b1) begin
            errors++; $display("FAIL hold_m1_grant: strobes after %0d cycles gnt=%b want 6 1", cyc, gnt);
        end
        wait_ack(1, 40, cyc, ok);
        m1_req_ = 1'b1;
        checks++;
        if (!ok || m1_err !== 1'b0 || m1_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_m1_ack: ok=%0d err=%b rdata=%h want 1 0 deadbeef", ok, m1_err, m1_rdata);
        end
        stretch_n = 0;
        wait_idle(ok);
    endtask

    task automatic test_req_drop;
        int cyc; bit ok;
        int acks = 0;
        m0_addr = 5'd3; m0_we_ = 1'b1; m0_req_ = 1'b0;
        @(negedge clk);
        m0_req_ = 1'b1;
        wait_ack(0, 40, cyc, ok);
        checks++;
        if (!ok || cyc != 2) begin
            errors++; $display("FAIL drop_ack: ack seen=%0d after %0d+1 cycles want 2+1", ok, cyc);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_ack_ === 1'b0) acks++;
        end
        checks++;
        if (acks != 0 || busy !== 1'b0 || rf_cs_ !== 1'b1) begin
            errors++; $display("FAIL drop_idle: extra acks=%0d busy=%b cs_=%b want 0 0 1", acks, busy, rf_cs_);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_access;
        test_write_read;
        test_round_robin;
        test_timeout;
        test_release_hold;
        test_req_drop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
